// File: rtl/warbiter_resp_router.sv
// Response router for the weighted round-robin arbiter: records each issued
// grant in an in-order tag FIFO and steers returning responses to the owner.
module warbiter_resp_router #(
    parameter int unsigned VECTOR_IN  = 8,
    parameter int unsigned TAG_DEPTH  = 8,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [VECTOR_IN-1:0]         grant,
    input  logic                         issue_ready,
    output logic                         issue_allow,
    input  logic                         resp_valid,
    input  logic [DATA_WIDTH-1:0]        resp_data,
    output logic                         resp_ready,
    output logic [VECTOR_IN-1:0]         req_resp_valid,
    output logic [DATA_WIDTH-1:0]        req_resp_data,
    input  logic [VECTOR_IN-1:0]         req_resp_ack,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         orphan_error,
    output logic                         grant_error
);

    localparam int unsigned IDW = $clog2(VECTOR_IN);
    localparam int unsigned PW  = $clog2(TAG_DEPTH);
    localparam int unsigned CW  = PW + 1;

    logic [IDW-1:0] tag_q [TAG_DEPTH];
    logic [PW:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           orphan_q, orphan_d;
    logic           gerr_q, gerr_d;

    logic           full;
    logic           empty;
    logic           issue_fire;
    logic           pop_fire;
    logic           grant_multi;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] head_id;

    // Full/empty from wrap-bit pointers
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    end

    // Lowest-set-bit encoder for the grant vector, plus one-hot violation detect
    always_comb begin
        grant_idx = '0;
        for (int i = int'(VECTOR_IN) - 1; i >= 0; i--) begin
            if (grant[i]) begin
                grant_idx = IDW'(i);
            end
        end
        grant_multi = ((grant & (grant - VECTOR_IN'(1))) != '0);
    end

    // Steering of the response toward the head-of-queue owner
    always_comb begin
        head_id        = tag_q[rd_ptr_q[PW-1:0]];
        issue_allow    = !full;
        issue_fire     = (|grant) && issue_ready && !full;
        req_resp_valid = '0;
        if (resp_valid && !empty) begin
            req_resp_valid[head_id] = 1'b1;
        end
        req_resp_data  = resp_data;
        resp_ready     = !empty && req_resp_ack[head_id];
        pop_fire       = resp_valid && resp_ready;
        outstanding    = cnt_q;
        orphan_error   = orphan_q;
        grant_error    = gerr_q;
    end

    // Next-state for pointers, occupancy and sticky error flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        orphan_d = orphan_q;
        gerr_d   = gerr_q;
        if (issue_fire) begin
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (grant_multi) begin
                gerr_d = 1'b1;
            end
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
        case ({issue_fire, pop_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (resp_valid && empty) begin
            orphan_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            orphan_q <= 1'b0;
            gerr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
            gerr_q   <= gerr_d;
        end
    end

    // Tag storage, written at the write pointer on each issue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_q[i] <= '0;
            end
        end else if (issue_fire) begin
            tag_q[wr_ptr_q[PW-1:0]] <= grant_idx;
        end
    end

endmodule
